// File: rtl/latch_bank_write_arbiter.sv
// latch_bank_write_arbiter
//   Shares one bank of 2**ADDR_W active-low-gated D-latch words among NREQ
//   write requesters. One write at a time, each sequenced as
//   SETUP (data driven, gates closed) -> OPEN (one gate transparent)
//   -> HOLD (gates closed, data still driven), so latch setup/hold around
//   both gate edges is met by construction.
//
//   Every output is a register loaded from the next-state decode, so there
//   is no combinational path from any input to any output.
//
// Ports
//   clk_i      clock, all state updates on the rising edge
//   r_i        synchronous active-high reset
//   req_i      per-requester write request (level, held until done)
//   addr_i     per-requester word address, slice i = [i*ADDR_W +: ADDR_W]
//   wdata_i    per-requester write data,   slice i = [i*W +: W]
//   gnt_o      one-hot grant, high from SETUP through HOLD of the owner
//   done_o     one-cycle pulse in the final HOLD cycle
//   busy_o     high in any state other than IDLE
//   lat_d_o    data bus to every latch word
//   lat_g_n_o  per-word gate, active-low (0 = transparent)
//   lat_r_o    bank clear, active-high
//
// Configuration
//   LATCH_ARB_FIXED_PRIO_EN  defined: lowest-index request always wins and
//                            no round-robin pointer exists (starvation of
//                            higher indices is possible).
//                            undefined: round-robin from the pointer.
module latch_bank_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 8,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     clk_i,
    input  logic                     r_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*W-1:0]        wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          done_o,
    output logic                     busy_o,
    output logic [W-1:0]             lat_d_o,
    output logic [(1<<ADDR_W)-1:0]   lat_g_n_o,
    output logic                     lat_r_o
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int IDX_W   = $clog2(NREQ);
    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {CLR, IDLE, SETUP, OPEN, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [W-1:0]        data_q, data_d;

    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                busy_q, busy_d;
    logic [W-1:0]        lat_d_q, lat_d_d;
    logic [DEPTH-1:0]    lat_g_n_q, lat_g_n_d;
    logic                lat_r_q, lat_r_d;

    logic [NREQ-1:0]     rot;
    logic [IDX_W-1:0]    pick;
    logic [NREQ-1:0]     win_oh;

    // ------------------------------------------------------------------
    // Winner selection. Requests are rotated so the pointer position sits
    // at bit 0; the lowest set bit of the rotated vector is the winner.
    // ------------------------------------------------------------------
`ifdef LATCH_ARB_FIXED_PRIO_EN
    assign rot = req_i;

    always_comb begin
        pick = '0;
        // Descending scan: the last hit (lowest index) wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) pick = IDX_W'(k);
        end
    end
`else
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [2*NREQ-1:0]   req_dbl;

    assign req_dbl = {req_i, req_i} >> ptr_q;
    assign rot     = req_dbl[NREQ-1:0];

    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) pick = IDX_W'((int'(ptr_q) + k) % NREQ);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next state, phase counter and captured transaction
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifndef LATCH_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            CLR: state_d = IDLE;
            IDLE: begin
                if (|req_i) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    win_d   = pick;
                    addr_d  = addr_i[pick*ADDR_W +: ADDR_W];
                    data_d  = wdata_i[pick*W +: W];
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = OPEN;
                    cnt_d   = CNT_W'(EN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
`ifndef LATCH_ARB_FIXED_PRIO_EN
                    ptr_d   = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = CLR;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs line up
    // with the state they describe. lat_d follows the captured data, which
    // only changes on capture in IDLE; it is therefore frozen from SETUP
    // through HOLD, covering the whole time a gate can be low plus the
    // cycle(s) after it rises.
    // ------------------------------------------------------------------
    assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_d;

    always_comb begin
        gnt_d     = '0;
        done_d    = '0;
        lat_g_n_d = '1;
        lat_r_d   = (state_d == CLR);
        busy_d    = (state_d != IDLE);
        lat_d_d   = data_d;
        if (state_d == SETUP || state_d == OPEN || state_d == HOLD)
            gnt_d = win_oh;
        if (state_d == OPEN)
            lat_g_n_d[addr_d] = 1'b0;
        if (state_d == HOLD && cnt_d == '0)
            done_d = win_oh;
    end

    always_ff @(posedge clk_i) begin
        if (r_i) begin
            state_q   <= CLR;
            cnt_q     <= '0;
            win_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b1;
            lat_d_q   <= '0;
            lat_g_n_q <= '1;
            lat_r_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            lat_d_q   <= lat_d_d;
            lat_g_n_q <= lat_g_n_d;
            lat_r_q   <= lat_r_d;
        end
    end

`ifndef LATCH_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i) begin
        if (r_i) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign lat_d_o   = lat_d_q;
    assign lat_g_n_o = lat_g_n_q;
    assign lat_r_o   = lat_r_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
module tb_latch_bank_write_arbiter;

    logic        clk = 1'b0;
    logic        r   = 1'b1;
    logic [3:0]  req   = '0;
    logic [7:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt, done, lat_g_n;
    logic        busy, lat_r;
    logic [7:0]  lat_d;

    latch_bank_write_arbiter #(
        .NREQ(4), .W(8), .ADDR_W(2), .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)
    ) dut (
        .clk_i(clk), .r_i(r), .req_i(req), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .done_o(done), .busy_o(busy), .lat_d_o(lat_d),
        .lat_g_n_o(lat_g_n), .lat_r_o(lat_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        int         a;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: latch bank model, per-cycle invariants, scoreboard pop on done
    // ------------------------------------------------------------------
    logic [7:0] bank [4];
    logic [7:0] prev_d   = '0;
    logic       prev_low = 1'b0;
    logic       prev_r   = 1'b1;
    exp_t       e;

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("one_gate_low", 32'($countones(~lat_g_n) <= 1), 32'd1);
            if (!prev_r && (prev_low || lat_g_n != 4'hF))
                chk("lat_d_stable", lat_d, prev_d);

            for (int k = 0; k < 4; k++) begin
                if (lat_r)            bank[k] = '0;
                else if (!lat_g_n[k]) bank[k] = lat_d;
            end

            if (done !== 4'h0) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", done, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_vec",     done,      32'(1 << e.idx));
                    chk("done_cyc",     cyc,       e.cyc);
                    chk("gnt_at_done",  gnt,       32'(1 << e.idx));
                    chk("word_written", bank[e.a], e.d);
                end
            end
            prev_d   = lat_d;
            prev_low = (lat_g_n != 4'hF);
            prev_r   = r;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input logic [7:0] d);
        req[i]           = 1'b1;
        addr[i*2 +: 2]   = 2'(a);
        wdata[i*8 +: 8]  = d;
    endtask

    int c;

    initial begin
        // Reset state
        step(); step();
        chk("rst_lat_r",   lat_r,   32'd1);
        chk("rst_gnt",     gnt,     32'h0);
        chk("rst_gate",    lat_g_n, 32'hF);
        chk("rst_done",    done,    32'h0);
        chk("rst_lat_d",   lat_d,   32'h0);
        chk("rst_busy",    busy,    32'd1);
        r = 1'b0;
        step();
        chk("clr_one_cycle", lat_r, 32'd0);
        chk("idle_busy",     busy,  32'd0);

`ifndef LATCH_ARB_FIXED_PRIO_EN
        // Single write: req1, addr 3, A5
        set_req(1, 3, 8'hA5);
        sbq.push_back('{1, 3, 8'hA5, cyc + 4});
        step();
        chk("sw_gnt",        gnt,     32'b0010);
        chk("sw_lat_d",      lat_d,   32'hA5);
        chk("sw_gate_setup", lat_g_n, 32'hF);
        req = '0;
        step(); chk("sw_gate_open1", lat_g_n, 32'b0111);
        step(); chk("sw_gate_open2", lat_g_n, 32'b0111);
        step(); chk("sw_gate_hold",  lat_g_n, 32'hF);
        step(); chk("sw_idle_busy",  busy,    32'd0);
        chk("sw_idle_gnt", gnt, 32'h0);

        // Reset in the middle of OPEN: write aborted, no done
        set_req(0, 2, 8'h3C);
        step();
        req = '0;
        step(); chk("rmo_open", lat_g_n, 32'b1011);
        r = 1'b1;
        step();
        chk("rmo_gate",  lat_g_n, 32'hF);
        chk("rmo_gnt",   gnt,     32'h0);
        chk("rmo_lat_r", lat_r,   32'd1);
        r = 1'b0;
        step();
        chk("rmo_clr_end", lat_r, 32'd0);
        chk("rmo_busy",    busy,  32'd0);

        // All four held: grants 0,1,2,3,0, five cycles apart
        for (int i = 0; i < 4; i++) set_req(i, i, 8'(8'h10 + i));
        c = cyc;
        for (int k = 0; k < 5; k++)
            sbq.push_back('{k % 4, k % 4, 8'(8'h10 + k % 4), c + 4 + 5 * k});
        for (int j = 1; j <= 22; j++) begin
            step();
            if (j % 5 == 1) chk("rr_gnt", gnt, 32'(1 << ((j / 5) % 4)));
        end
        req = '0;
        repeat (4) step();
        chk("rr_idle", busy, 32'd0);

        // req2 dropped during SETUP: write still completes
        set_req(2, 1, 8'h5A);
        sbq.push_back('{2, 1, 8'h5A, cyc + 4});
        step();
        chk("drop_gnt", gnt, 32'b0100);
        req = '0;
        repeat (4) step();
        chk("drop_idle", busy, 32'd0);

        // Pointer now at 3: req3 wins, then wraps to req0
        set_req(0, 0, 8'hC3);
        set_req(3, 2, 8'h96);
        c = cyc;
        sbq.push_back('{3, 2, 8'h96, c + 4});
        sbq.push_back('{0, 0, 8'hC3, c + 9});
        step();
        chk("wrap_gnt3", gnt, 32'b1000);
        req[3] = 1'b0;
        repeat (5) step();
        chk("wrap_gnt0", gnt, 32'b0001);
        req = '0;
        repeat (4) step();
        chk("wrap_idle", busy, 32'd0);
`else
        // Fixed priority: req0 and req3 held, req0 wins every time
        set_req(0, 1, 8'h11);
        set_req(3, 3, 8'h33);
        c = cyc;
        for (int k = 0; k < 3; k++)
            sbq.push_back('{0, 1, 8'h11, c + 4 + 5 * k});
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j % 5 == 1) chk("fp_gnt", gnt, 32'b0001);
        end
        req = '0;
        repeat (4) step();
        chk("fp_idle", busy, 32'd0);
`endif

        repeat (2) step();
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
